// File: rtl/alu_cdb_arbiter_if.sv
// alu_cdb_arbiter_if: ALU, load/store, flush and CDB/ROB signals between the producers and the CDB arbiter.
`ifndef aluRSWidth
`define aluRSWidth 3
`endif
`ifndef tagWidth
`define tagWidth 4
`endif
`ifndef dataWidth
`define dataWidth 32
`endif
`ifndef tagFree
`define tagFree 4'd0
`endif

interface alu_cdb_arbiter_if;
    logic                    aluSignal;
    logic [`aluRSWidth-1:0]  ALU_CDB_out_RSnum;
    logic [`tagWidth-1:0]    ALU_CDB_out_tag;
    logic [`dataWidth-1:0]   ALU_CDB_out_data;
    logic                    ls_valid;
    logic [`tagWidth-1:0]    ls_tag;
    logic [`dataWidth-1:0]   ls_data;
    logic                    ls_ready;
    logic                    mispredictionRst;
    logic                    aluFinish;
    logic [`aluRSWidth-1:0]  ALU_CDB_RSnum;
    logic [`tagWidth-1:0]    ALU_CDB_tag;
    logic [`dataWidth-1:0]   ALU_CDB_data;
    logic                    LSBuf_CDB_valid;
    logic [`tagWidth-1:0]    LSBuf_CDB_tag;
    logic [`dataWidth-1:0]   LSBuf_CDB_data;
    logic                    rob_wr_en;
    logic [`tagWidth-1:0]    rob_wr_tag;
    logic [`dataWidth-1:0]   rob_wr_data;

    modport master (
        output aluSignal, ALU_CDB_out_RSnum, ALU_CDB_out_tag, ALU_CDB_out_data,
        output ls_valid, ls_tag, ls_data, mispredictionRst,
        input  ls_ready, aluFinish, ALU_CDB_RSnum, ALU_CDB_tag, ALU_CDB_data,
        input  LSBuf_CDB_valid, LSBuf_CDB_tag, LSBuf_CDB_data,
        input  rob_wr_en, rob_wr_tag, rob_wr_data
    );

    modport slave (
        input  aluSignal, ALU_CDB_out_RSnum, ALU_CDB_out_tag, ALU_CDB_out_data,
        input  ls_valid, ls_tag, ls_data, mispredictionRst,
        output ls_ready, aluFinish, ALU_CDB_RSnum, ALU_CDB_tag, ALU_CDB_data,
        output LSBuf_CDB_valid, LSBuf_CDB_tag, LSBuf_CDB_data,
        output rob_wr_en, rob_wr_tag, rob_wr_data
    );
endinterface

// File: rtl/alu_cdb_arbiter.sv
// alu_cdb_arbiter: registered CDB arbiter; ALU results win, load/store results queue in a FIFO.
// Define CDB_LS_BYPASS_EN to let a load/store result skip the empty FIFO on an idle bus.
`ifndef aluRSWidth
`define aluRSWidth 3
`endif
`ifndef tagWidth
`define tagWidth 4
`endif
`ifndef dataWidth
`define dataWidth 32
`endif
`ifndef tagFree
`define tagFree 4'd0
`endif

module alu_cdb_arbiter #(
    parameter int LS_FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    alu_cdb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(LS_FIFO_DEPTH);

    logic [`tagWidth-1:0]  mem_tag  [LS_FIFO_DEPTH];
    logic [`dataWidth-1:0] mem_data [LS_FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  flush, dup, alu_acc, empty, byp, pop, push, sel_alu, sel_ls;
    logic [`tagWidth-1:0]  ls_tag_n;
    logic [`dataWidth-1:0] ls_data_n;

    assign bus.ls_ready = count != (AW+1)'(LS_FIFO_DEPTH);

    always_comb begin
        flush     = bus.mispredictionRst;
        // The station re-issues an entry once before it sees the free; drop that copy.
        dup       = bus.aluSignal & bus.aluFinish & (bus.ALU_CDB_out_RSnum == bus.ALU_CDB_RSnum) & (bus.ALU_CDB_out_tag == bus.ALU_CDB_tag);
        alu_acc   = bus.aluSignal & !dup;
        empty     = count == '0;
`ifdef CDB_LS_BYPASS_EN
        byp       = empty & !alu_acc & bus.ls_valid;
`else
        byp       = 1'b0;
`endif
        pop       = !alu_acc & !empty;
        push      = bus.ls_valid & bus.ls_ready & !byp;
        sel_alu   = alu_acc & !flush;
        sel_ls    = (pop | byp) & !flush;
        ls_tag_n  = pop ? mem_tag[rd_ptr] : bus.ls_tag;
        ls_data_n = pop ? mem_data[rd_ptr] : bus.ls_data;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_tag[wr_ptr]  <= bus.ls_tag;
            mem_data[wr_ptr] <= bus.ls_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Flush is folded into sel_alu/sel_ls, so it yields the same idle values as reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.aluFinish       <= 1'b0;
            bus.ALU_CDB_RSnum   <= '0;
            bus.ALU_CDB_tag     <= `tagFree;
            bus.ALU_CDB_data    <= '0;
            bus.LSBuf_CDB_valid <= 1'b0;
            bus.LSBuf_CDB_tag   <= `tagFree;
            bus.LSBuf_CDB_data  <= '0;
            bus.rob_wr_en       <= 1'b0;
            bus.rob_wr_tag      <= `tagFree;
            bus.rob_wr_data     <= '0;
        end else begin
            bus.aluFinish       <= sel_alu;
            bus.ALU_CDB_RSnum   <= sel_alu ? bus.ALU_CDB_out_RSnum : '0;
            bus.ALU_CDB_tag     <= sel_alu ? bus.ALU_CDB_out_tag : `tagFree;
            bus.ALU_CDB_data    <= sel_alu ? bus.ALU_CDB_out_data : '0;
            bus.LSBuf_CDB_valid <= sel_ls;
            bus.LSBuf_CDB_tag   <= sel_ls ? ls_tag_n : `tagFree;
            bus.LSBuf_CDB_data  <= sel_ls ? ls_data_n : '0;
            bus.rob_wr_en       <= sel_alu | sel_ls;
            bus.rob_wr_tag      <= sel_alu ? bus.ALU_CDB_out_tag : sel_ls ? ls_tag_n : `tagFree;
            bus.rob_wr_data     <= sel_alu ? bus.ALU_CDB_out_data : sel_ls ? ls_data_n : '0;
        end
    end
endmodule

// File: tb/tb_alu_cdb_arbiter.sv
// tb_alu_cdb_arbiter: directed checks of alu_cdb_arbiter (dup drop, priority, FIFO wrap, flush, reset).
`ifndef aluRSWidth
`define aluRSWidth 3
`endif
`ifndef tagWidth
`define tagWidth 4
`endif
`ifndef dataWidth
`define dataWidth 32
`endif
`ifndef tagFree
`define tagFree 4'd0
`endif

module tb_alu_cdb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
`ifdef CDB_LS_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    alu_cdb_arbiter_if bus ();
    alu_cdb_arbiter #(.LS_FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", n, o, e);
        end
    endtask

    task automatic chk_alu(input string n, input logic f, input int rs, input int t, input int d);
        chk({n, ".aluFinish"}, 32'(bus.aluFinish), 32'(f));
        chk({n, ".alu_rs"}, 32'(bus.ALU_CDB_RSnum), f ? 32'(rs) : 32'd0);
        chk({n, ".alu_tag"}, 32'(bus.ALU_CDB_tag), f ? 32'(t) : 32'(`tagFree));
        chk({n, ".alu_data"}, 32'(bus.ALU_CDB_data), f ? 32'(d) : 32'd0);
    endtask

    task automatic chk_ls(input string n, input logic v, input int t, input int d);
        chk({n, ".ls_valid"}, 32'(bus.LSBuf_CDB_valid), 32'(v));
        chk({n, ".ls_tag"}, 32'(bus.LSBuf_CDB_tag), v ? 32'(t) : 32'(`tagFree));
        chk({n, ".ls_data"}, 32'(bus.LSBuf_CDB_data), v ? 32'(d) : 32'd0);
    endtask

    task automatic chk_rob(input string n, input logic v, input int t, input int d);
        chk({n, ".rob_en"}, 32'(bus.rob_wr_en), 32'(v));
        chk({n, ".rob_tag"}, 32'(bus.rob_wr_tag), v ? 32'(t) : 32'(`tagFree));
        chk({n, ".rob_data"}, 32'(bus.rob_wr_data), v ? 32'(d) : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.aluSignal = 1'b0;
        bus.ALU_CDB_out_RSnum = '0;
        bus.ALU_CDB_out_tag = '0;
        bus.ALU_CDB_out_data = '0;
        bus.ls_valid = 1'b0;
        bus.ls_tag = '0;
        bus.ls_data = '0;
        bus.mispredictionRst = 1'b0;
    endtask

    task automatic alu(input int rs, input int t, input int d);
        bus.aluSignal = 1'b1;
        bus.ALU_CDB_out_RSnum = `aluRSWidth'(rs);
        bus.ALU_CDB_out_tag = `tagWidth'(t);
        bus.ALU_CDB_out_data = `dataWidth'(d);
    endtask

    task automatic ls(input int t, input int d);
        bus.ls_valid = 1'b1;
        bus.ls_tag = `tagWidth'(t);
        bus.ls_data = `dataWidth'(d);
    endtask

    initial begin
        idle();
        #3;
        chk_alu("reset", 1'b0, 0, 0, 0);
        chk_ls("reset", 1'b0, 0, 0);
        chk_rob("reset", 1'b0, 0, 0);
        chk("reset.ready", 32'(bus.ls_ready), 32'd1);
        #4 rst = 1'b1;

        // ALU result then its duplicate re-issue
        alu(2, 5, 'h10);
        tick();
        chk_alu("alu1", 1'b1, 2, 5, 'h10);
        chk_ls("alu1", 1'b0, 0, 0);
        chk_rob("alu1", 1'b1, 5, 'h10);
        tick();
        chk_alu("dup", 1'b0, 0, 0, 0);
        chk_rob("dup", 1'b0, 0, 0);
        idle();
        tick();
        chk_alu("post_dup", 1'b0, 0, 0, 0);

        // Single load/store result on an idle bus
        ls(3, 'h33);
        tick();
        chk_ls("ls_n", LAT == 1, 3, 'h33);
        idle();
        tick();
        chk_ls("ls_n1", LAT == 2, 3, 'h33);
        chk_rob("ls_n1", LAT == 2, 3, 'h33);
        tick();
        chk_ls("ls_n2", 1'b0, 0, 0);

        // ALU priority starves the FIFO until it fills
        for (int i = 0; i < 6; i++) begin
            int t;
            t = (i == 0) ? 7 : (i < 4) ? 10 + i : 14;
            alu(i, i + 1, 'h100 + i);
            ls(t, t * 16);
            tick();
            chk_alu("starve", 1'b1, i, i + 1, 'h100 + i);
            chk_ls("starve", 1'b0, 0, 0);
            chk("starve.ready", 32'(bus.ls_ready), 32'(i < 3));
        end
        idle();
        tick();
        chk_alu("drain7", 1'b0, 0, 0, 0);
        chk_ls("drain7", 1'b1, 7, 'h70);
        chk_rob("drain7", 1'b1, 7, 'h70);
        chk("drain7.ready", 32'(bus.ls_ready), 32'd1);
        for (int t = 11; t <= 13; t++) begin
            tick();
            chk_ls("drain", 1'b1, t, t * 16);
        end
        tick();
        chk_ls("drain_end", 1'b0, 0, 0);

        // Ten results in order through a wrapping FIFO
        for (int e = 1; e <= 12; e++) begin
            int x;
            if (e <= 10) ls(e, 'h200 + e);
            else idle();
            tick();
            x = e - (LAT - 1);
            chk_ls("wrap", x >= 1 && x <= 10, x, 'h200 + x);
            chk("wrap.ready", 32'(bus.ls_ready), 32'd1);
        end
        idle();
        tick();

        // Flush with two queued results and live inputs
        alu(1, 1, 'h11);
        ls(9, 'h99);
        tick();
        alu(2, 2, 'h22);
        ls(10, 'haa);
        tick();
        chk("flush_pre.ready", 32'(bus.ls_ready), 32'd1);
        alu(3, 4, 'h44);
        ls(11, 'hbb);
        bus.mispredictionRst = 1'b1;
        tick();
        chk_alu("flush", 1'b0, 0, 0, 0);
        chk_ls("flush", 1'b0, 0, 0);
        chk_rob("flush", 1'b0, 0, 0);
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ls("post_flush", 1'b0, 0, 0);
            chk_alu("post_flush", 1'b0, 0, 0, 0);
        end

        // Asynchronous reset with three queued results
        for (int i = 1; i <= 3; i++) begin
            alu(i, i + 8, 'h300 + i);
            ls(i + 3, 'h400 + i);
            tick();
        end
        chk_alu("pre_rst", 1'b1, 3, 11, 'h303);
        #2 rst = 1'b0;
        #1;
        chk_alu("async_rst", 1'b0, 0, 0, 0);
        chk_ls("async_rst", 1'b0, 0, 0);
        chk_rob("async_rst", 1'b0, 0, 0);
        chk("async_rst.ready", 32'(bus.ls_ready), 32'd1);
        idle();
        #1 rst = 1'b1;
        tick();
        chk_ls("after_rst", 1'b0, 0, 0);
        chk_alu("after_rst", 1'b0, 0, 0, 0);
        chk("after_rst.ready", 32'(bus.ls_ready), 32'd1);
        tick();
        chk_ls("after_rst2", 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
